// File: rtl/fa4_pkg.sv
// fa4_pkg: shared constants, types and helpers for the fa4_add_reg adder stage.
//   FA4_WIDTH      - default operand / sum width (4 bits)
//   fa4_operand_t  - FA4_WIDTH-bit unsigned operand
//   fa4_result_t   - FA4_WIDTH+1-bit {carry, sum} result
//   fa4_ovf        - two's-complement overflow from the carries around the MSB
package fa4_pkg;

  localparam int FA4_WIDTH = 4;

  typedef logic [FA4_WIDTH-1:0] fa4_operand_t;
  typedef logic [FA4_WIDTH:0]   fa4_result_t;

  // Signed overflow occurs exactly when the carry into the MSB differs from
  // the carry out of it.
  function automatic logic fa4_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/fa1_cell.sv
// fa1_cell: single-bit full adder, one link of the ripple chain.
//   a, b - operand bits
//   ci   - carry in
//   s    - sum bit
//   co   - carry out
module fa1_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p_s;

  // Propagate term is shared by the sum and the carry.
  assign p_s = a ^ b;
  assign s   = p_s ^ ci;
  assign co  = (a & b) | (ci & p_s);

endmodule

// File: rtl/fa4_xchk_chk.sv
// fa4_xchk_chk: simulation checker flagging any accepted input whose ripple
// result disagrees with the behavioural reference sum.
//   clk, rst_n - clock and asynchronous active-low reset
//   in_valid   - input accepted this cycle
//   mismatch   - ripple {co, s} differs from reference {co_ref, s_ref}
module fa4_xchk_chk (
  input logic clk,
  input logic rst_n,
  input logic in_valid,
  input logic mismatch
);

  // Ripple and reference must agree on every accepted input.
  a_ripple_matches_ref: assert property (
    @(posedge clk) disable iff (!rst_n) !(in_valid && mismatch)
  ) else $error("fa4_add_reg: ripple result disagrees with reference sum");

endmodule

// File: rtl/fa4_add_reg.sv
// fa4_add_reg: registered WIDTH-bit ripple-carry adder, {co, s} = a + b + ci.
// Inputs are sampled when in_valid is high; the result appears one cycle later
// with out_valid set. Outputs hold when no input is accepted.
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   in_valid     - sample a, b, ci this edge
//   a, b, ci     - unsigned operands and carry in
//   out_valid    - s, co, ovf carry a fresh result
//   s, co, ovf   - registered sum, carry out, two's-complement overflow
// Build option FA4_XCHK_EN adds a behavioural reference path and a sticky
// output xchk_err that is set when the ripple chain disagrees with it.
module fa4_add_reg
  import fa4_pkg::*;
#(
  parameter int WIDTH = FA4_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
`ifdef FA4_XCHK_EN
  ,
  output logic             xchk_err
`endif
);

  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] s_r;
  logic             co_r;
  logic             ovf_r;

  assign c_s[0] = ci;

  // Ripple chain: carry of cell i feeds cell i+1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    fa1_cell u_fa1 (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c_s[i]),
      .s  (sum_s[i]),
      .co (c_s[i+1])
    );
  end

  assign ovf_s = fa4_ovf(c_s[WIDTH-1], c_s[WIDTH]);

  // Result register; data only loads on accepted input so idle X never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      s_r         <= {WIDTH{1'b0}};
      co_r        <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        s_r   <= sum_s;
        co_r  <= c_s[WIDTH];
        ovf_r <= ovf_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign co        = co_r;
  assign ovf       = ovf_r;

`ifdef FA4_XCHK_EN
  logic [WIDTH:0] ref_s;
  logic           mismatch_s;
  logic           xchk_err_r;

  assign ref_s      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  assign mismatch_s = ({c_s[WIDTH], sum_s} != ref_s);

  // Sticky cross-check flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xchk_err_r <= 1'b0;
    end else if (in_valid && mismatch_s) begin
      xchk_err_r <= 1'b1;
    end
  end

  assign xchk_err = xchk_err_r;

  fa4_xchk_chk u_xchk_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .mismatch (mismatch_s)
  );
`endif

endmodule

// File: tb/tb_fa4_add_reg.sv
// tb_fa4_add_reg: directed and streaming checks of fa4_add_reg (default WIDTH).
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
module tb_fa4_add_reg;
  import fa4_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  fa4_operand_t a;
  fa4_operand_t b;
  logic         ci;
  logic         out_valid;
  fa4_operand_t s;
  logic         co;
  logic         ovf;
`ifdef FA4_XCHK_EN
  logic         xchk_err;
`endif

  int n_vec;
  int n_err;

  fa4_add_reg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .s         (s),
    .co        (co),
    .ovf       (ovf)
`ifdef FA4_XCHK_EN
    ,
    .xchk_err  (xchk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log a miscompare.
  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Independent model: unsigned {carry, sum} and signed overflow via integers.
  function automatic fa4_result_t gold_sum(input fa4_operand_t x, input fa4_operand_t y, input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return fa4_result_t'(t);
  endfunction

  function automatic logic gold_ovf(input fa4_operand_t x, input fa4_operand_t y, input logic c);
    int sx, sy, t;
    sx = (x >= 4'd8) ? int'(x) - 16 : int'(x);
    sy = (y >= 4'd8) ? int'(y) - 16 : int'(y);
    t  = sx + sy + int'(c);
    return (t > 7) || (t < -8);
  endfunction

  task automatic drive(input logic v, input fa4_operand_t x, input fa4_operand_t y, input logic c);
    in_valid = v;
    a        = x;
    b        = y;
    ci       = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one accepted vector and check its result one edge later.
  task automatic apply_chk(input string tag, input fa4_operand_t x, input fa4_operand_t y, input logic c,
                           input fa4_operand_t es, input logic eco, input logic eovf);
    drive(1'b1, x, y, c);
    step();
    chk_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk_eq({tag, ".s"},     32'(s),         32'(es));
    chk_eq({tag, ".co"},    32'(co),        32'(eco));
    chk_eq({tag, ".ovf"},   32'(ovf),       32'(eovf));
  endtask

  initial begin
    fa4_result_t  g;
    fa4_operand_t ra, rb;
    logic         rc;
    n_vec = 0;
    n_err = 0;

    // Reset held with live inputs.
    rst_n = 1'b0;
    drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
    repeat (3) step();
    chk_eq("rst.valid", 32'(out_valid), 32'd0);
    chk_eq("rst.s",     32'(s),         32'd0);
    chk_eq("rst.co",    32'(co),        32'd0);
    chk_eq("rst.ovf",   32'(ovf),       32'd0);
`ifdef FA4_XCHK_EN
    chk_eq("rst.xchk", 32'(xchk_err), 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    step();
    chk_eq("zero.valid", 32'(out_valid), 32'd1);
    chk_eq("zero.s",     32'(s),         32'd0);
    chk_eq("zero.co",    32'(co),        32'd0);

    apply_chk("ident",  4'd5,  4'd0,  1'b1, 4'd6,  1'b0, 1'b0);
    apply_chk("carry",  4'd9,  4'd7,  1'b0, 4'd0,  1'b1, 1'b0);
    apply_chk("ovf",    4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1);
    apply_chk("wrap",   4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);

    // Idle cycles with moving operands: outputs must hold 15/1/0.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'(k + 3), 4'(k * 5), k[0]);
      if (k == 1) begin
        a  = 'x;
        ci = 'x;
      end
      step();
      chk_eq("idle.valid", 32'(out_valid), 32'd0);
      chk_eq("idle.s",     32'(s),         32'd15);
      chk_eq("idle.co",    32'(co),        32'd1);
      chk_eq("idle.ovf",   32'(ovf),       32'd0);
    end

    // Back-to-back random stream.
    for (int k = 0; k < 512; k++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      drive(1'b1, ra, rb, rc);
      g = gold_sum(ra, rb, rc);
      step();
      chk_eq("strm.valid", 32'(out_valid), 32'd1);
      chk_eq("strm.sum",   32'({co, s}),   32'(g));
      chk_eq("strm.ovf",   32'(ovf),       32'(gold_ovf(ra, rb, rc)));
    end
`ifdef FA4_XCHK_EN
    chk_eq("strm.xchk", 32'(xchk_err), 32'd0);
`endif

    // Mid-cycle reset during streaming clears outputs without a clock edge.
    apply_chk("pre", 4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0);
    drive(1'b1, 4'd12, 4'd2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("async.valid", 32'(out_valid), 32'd0);
    chk_eq("async.s",     32'(s),         32'd0);
    step();
    chk_eq("inrst.valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'd6, 4'd11, 1'b1);
    g = gold_sum(4'd6, 4'd11, 1'b1);
    step();
    chk_eq("post.valid", 32'(out_valid), 32'd1);
    chk_eq("post.sum",   32'({co, s}),   32'(g));
    chk_eq("post.ovf",   32'(ovf),       32'(gold_ovf(4'd6, 4'd11, 1'b1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fa4_add_reg.md
Name: fa4_add_reg

Overview:
- Registered 4-bit ripple-carry adder computing {co, s} = a + b + ci.
- Built from per-bit full-adder cells, with a behavioural multi-bit sum kept alongside as a reference path.
- Sits as a leaf arithmetic stage in datapaths; inputs are sampled under a valid qualifier and results are presented one cycle later.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a, b and ci are sampled when high.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- ci  input  1  carry in.
- out_valid  output  1  s, co and ovf hold a fresh result.
- s  output  WIDTH  registered sum bits.
- co  output  1  registered carry out.
- ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset:
  - rst_n low asynchronously clears s, co, ovf and out_valid to 0, regardless of clk.
  - Release is sampled on the next rising clk.
- Combinational ripple path:
  - c[0] = ci.
  - For bit i: sum_i = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - Raw carry out = c[WIDTH].
- Reference path: behavioural {co_ref, s_ref} = a + b + ci, zero-extended to WIDTH+1 bits.
- Outputs are always taken from the ripple path.
- Latency: one cycle. When in_valid is high at rising edge N:
  - s, co, ovf update with the ripple result of the values sampled at edge N.
  - out_valid = 1 after edge N.
- in_valid low at an edge: out_valid = 0; s, co and ovf hold their previous values.
- Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
- Wrap-around: a result above 2^WIDTH-1 wraps in s, and co = 1.
  - Example: 15+15+1 gives s=15, co=1.
- X on a, b or ci while in_valid is low must not propagate into registers.
- Reset asserted mid-stream: any in-flight result is discarded; out_valid = 0 until the next accepted input.

Optional Feature:
- Macro: FA4_XCHK_EN.
- When defined:
  - Adds output port xchk_err (1 bit).
  - xchk_err is registered with the same timing as out_valid.
  - It is set to 1 when an accepted input gives a ripple {co, s} that differs from the reference {co_ref, s_ref}.
  - It is sticky until rst_n is asserted; reset value is 0.
  - A simulation-only assertion fires on the mismatch.
- When not defined: the reference path, the port and the assertion are absent. Core behaviour is identical.

Decomposition:
- Package fa4_pkg holds:
  - the default WIDTH constant (4);
  - a typedef for the WIDTH-bit operand;
  - a typedef for the WIDTH+1-bit {carry, sum} result.
- One sub-module, fa1_cell: a 1-bit full adder (a, b, ci -> s, co).
  - Instantiated WIDTH times through a generate loop to form the ripple chain.

Test Plan:
- Reset: hold rst_n=0 with random inputs and in_valid=1 -> s=0, co=0, ovf=0, out_valid=0. Asynchronous clear is checked mid-cycle.
- Zero and identity: a=0, b=0, ci=0 -> s=0, co=0. Then a=5, b=0, ci=1 -> s=6, co=0. Each appears one cycle after its input with out_valid=1.
- Carry and overflow:
  - a=9, b=7, ci=0 -> s=0, co=1, ovf=0.
  - a=7, b=1, ci=0 -> s=8, co=0, ovf=1.
  - a=15, b=15, ci=1 -> s=15, co=1, ovf=0.
- Valid gating: in_valid=0 for 3 cycles with changing operands -> out_valid=0 and s/co hold their previous value.
- Streaming: 512 back-to-back random {ci, a, b} with in_valid=1 -> each output equals the golden (a+b+ci) one cycle later. With FA4_XCHK_EN defined, xchk_err stays 0.
- Reset mid-stream: assert rst_n during streaming -> out_valid=0 immediately. The first result after release corresponds to the first input accepted after release.
